// File: rtl/viterbi_k3_pkg.sv
// Shared types and helpers for the K=3 rate-1/2 Viterbi decoder.
// Trellis state is {u(t-1), u(t-2)}; generators g1=111, g0=101.
package viterbi_k3_pkg;

  localparam int NSTATES = 4;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    TRACE  = 2'd1,
    OUTPUT = 2'd2
  } fsm_e;

  function automatic logic [1:0] expected_sym(
    input logic u,
    input logic a,
    input logic b
  );
    return {u ^ a ^ b, u ^ b};
  endfunction

  function automatic logic [1:0] hamming2(
    input logic [1:0] x,
    input logic [1:0] y
  );
    logic [1:0] d;
    d = x ^ y;
    return {1'b0, d[1]} + {1'b0, d[0]};
  endfunction

endpackage

// File: rtl/viterbi_dec_k3_if.sv
// Symbol-in / bit-out stream bundle for the Viterbi decoder.
// slave = decoder side, master = producer/consumer side.
interface viterbi_dec_k3_if;
  logic [1:0] in_sym;
  logic       in_valid;
  logic       in_ready;
  logic       out_bit;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (
    output in_sym, in_valid, out_ready,
    input  in_ready, out_bit, out_valid, out_last
  );

  modport slave (
    input  in_sym, in_valid, out_ready,
    output in_ready, out_bit, out_valid, out_last
  );
endinterface

// File: rtl/viterbi_acs_k3.sv
// Combinational add-compare-select for all four trellis states.
// Ties resolve to the predecessor whose oldest bit is 0.
module viterbi_acs_k3
  import viterbi_k3_pkg::*;
#(
  parameter int MW = 8
) (
  input  logic [NSTATES-1:0][MW-1:0] metric_i,
  input  logic [1:0]                 sym_i,
  output logic [NSTATES-1:0][MW-1:0] metric_o,
  output logic [NSTATES-1:0]         dec_o
);

  for (genvar g = 0; g < NSTATES; g++) begin : g_ns
    localparam logic [1:0] NS = 2'(g);
    localparam logic [1:0] P0 = {NS[0], 1'b0};
    localparam logic [1:0] P1 = {NS[0], 1'b1};

    logic [MW:0]   sum0;
    logic [MW:0]   sum1;
    logic [MW-1:0] c0;
    logic [MW-1:0] c1;
    logic          pick1;

    assign sum0 = {1'b0, metric_i[P0]} + (MW+1)'(
      hamming2(sym_i, expected_sym(NS[1], NS[0], 1'b0)));
    assign sum1 = {1'b0, metric_i[P1]} + (MW+1)'(
      hamming2(sym_i, expected_sym(NS[1], NS[0], 1'b1)));

    // saturate so unreachable states never wrap below live ones
    assign c0 = sum0[MW] ? '1 : sum0[MW-1:0];
    assign c1 = sum1[MW] ? '1 : sum1[MW-1:0];

    assign pick1       = c1 < c0;
    assign dec_o[g]    = pick1;
    assign metric_o[g] = pick1 ? c1 : c0;
  end

endmodule

// File: rtl/viterbi_dec_k3.sv
// Frame-based hard-decision Viterbi decoder, K=3 rate 1/2.
// ACCEPT runs ACS per symbol, TRACE walks back from state 0, OUTPUT streams bits.
module viterbi_dec_k3
  import viterbi_k3_pkg::*;
#(
  parameter int FRAME_LEN = 32,
  parameter int MW        = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  viterbi_dec_k3_if.slave   io
);

  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] T_LAST = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] B_LAST = CW'(FRAME_LEN - 3);
  localparam logic [NSTATES-1:0][MW-1:0] M_INIT =
    {{((NSTATES-1)*MW){1'b1}}, {MW{1'b0}}};

  fsm_e                      state_q, state_d;
  logic                      en_q, en_d;
  logic [NSTATES-1:0][MW-1:0] metric_q, metric_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [CW-1:0]             p_q, p_d;
  logic [1:0]                tst_q, tst_d;

  logic [NSTATES-1:0]        surv_q [FRAME_LEN];
  logic                      obuf_q [FRAME_LEN-2];
  logic                      surv_we;
  logic                      obuf_we;

  logic [NSTATES-1:0][MW-1:0] acs_metric;
  logic [NSTATES-1:0]         acs_dec;

  viterbi_acs_k3 #(.MW(MW)) u_acs (
    .metric_i (metric_q),
    .sym_i    (io.in_sym),
    .metric_o (acs_metric),
    .dec_o    (acs_dec)
  );

  assign io.in_ready  = en_q && (state_q == ACCEPT);
  assign io.out_valid = (state_q == OUTPUT);
  assign io.out_last  = io.out_valid && (p_q == B_LAST);
  assign io.out_bit   = io.out_valid && obuf_q[p_q];
  assign busy         = (state_q != ACCEPT);

  always_comb begin
    state_d  = state_q;
    en_d     = 1'b1;
    metric_d = metric_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    tst_d    = tst_q;
    surv_we  = 1'b0;
    obuf_we  = 1'b0;
    unique case (state_q)
      ACCEPT: begin
        if (io.in_valid && io.in_ready) begin
          metric_d = acs_metric;
          surv_we  = 1'b1;
          if (cnt_q == T_LAST) begin
            state_d = TRACE;
            tst_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      TRACE: begin
        // tail symbols are walked but never stored
        tst_d   = {tst_q[0], surv_q[cnt_q][tst_q]};
        obuf_we = (cnt_q <= B_LAST);
        if (cnt_q == '0) begin
          state_d = OUTPUT;
          p_d     = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      OUTPUT: begin
        if (io.out_ready) begin
          if (p_q == B_LAST) begin
            state_d  = ACCEPT;
            metric_d = M_INIT;
            cnt_d    = '0;
            p_d      = '0;
          end else begin
            p_d = p_q + 1'b1;
          end
        end
      end
      default: state_d = ACCEPT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ACCEPT;
      en_q     <= 1'b0;
      metric_q <= M_INIT;
      cnt_q    <= '0;
      p_q      <= '0;
      tst_q    <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      metric_q <= metric_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      tst_q    <= tst_d;
    end
  end

  always_ff @(posedge clk) begin
    if (surv_we) surv_q[cnt_q] <= acs_dec;
    if (obuf_we) obuf_q[cnt_q] <= tst_q[1];
  end

endmodule
